// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   seg7_hex_decode : 4-bit nibble -> active-high {a,b,c,d,e,f,g}
//   SEG_OFF         : logical (active-high) all-unlit segment byte
//   seg7_idx_w      : width of a scan index for a given digit count
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic int seg7_idx_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Bit 6 = a ... bit 0 = g. Lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] seg7_hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: combinational dark-digit mask.
//   nib_i   : hex nibble per digit, digit 0 in [3:0]
//   blank_i : per-digit forced blank
//   lz_en_i : leading-zero suppression enable
//   dark_o  : 1 = digit must stay unlit
module seg7_lz_mask #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] nib_i,
  input  logic [DIGITS-1:0]   blank_i,
  input  logic                lz_en_i,
  output logic [DIGITS-1:0]   dark_o
);

  // zabove[i]: nibbles DIGITS-1 down to i are all zero.
  logic [DIGITS:1] zabove;
  assign zabove[DIGITS] = 1'b1;

  for (genvar i = DIGITS - 1; i >= 1; i--) begin : g_lz
    assign zabove[i] = zabove[i+1] & (nib_i[4*i +: 4] == 4'h0);
    assign dark_o[i] = blank_i[i] | (lz_en_i & zabove[i]);
  end

  // The rightmost digit is never zero-suppressed so a value of 0 still shows "0".
  assign dark_o[0] = blank_i[0];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed N-digit seven-segment driver.
//   mclk, rst_n : clock, async active-low reset
//   en          : display enable (anodes only; scanning keeps running)
//   digits, dp  : hex nibble and decimal point per digit, digit 0 rightmost
//   blank       : per-digit forced dark
//   lz_en       : leading-zero suppression
//   bright      : PWM duty, anode lit while pwm_cnt <= bright
//   seg         : {a,b,c,d,e,f,g,dp}, polarity SEG_ACTIVE_LOW
//   an          : digit enables, polarity AN_ACTIVE_LOW
//   frame_start : one-cycle pulse when the scan index wraps to 0
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 263157,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                mclk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  input  logic                lz_en,
  input  logic [3:0]          bright,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_start
);

  localparam int IDX_W = seg7_idx_w(DIGITS);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]    div_q;
  logic [IDX_W-1:0]    idx_q;
  logic [3:0]          pwm_q;
  logic [4*DIGITS-1:0] sh_dig_q;
  logic [DIGITS-1:0]   sh_dp_q, sh_blank_q;
  logic                sh_lz_q;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   an_q;
  logic                fs_q;

  logic                div_last, idx_last;
  logic [DIGITS-1:0]   dark;
  logic [3:0]          nib;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  assign div_last = (div_q == DIV_W'(SCAN_DIV - 1));
  assign idx_last = (idx_q == IDX_W'(DIGITS - 1));

  seg7_lz_mask #(.DIGITS(DIGITS)) u_lz (
    .nib_i   (sh_dig_q),
    .blank_i (sh_blank_q),
    .lz_en_i (sh_lz_q),
    .dark_o  (dark)
  );

  // Active-high next outputs. A digit dimmed by PWM or en keeps its glyph on
  // seg so only the anode toggles; a dark digit drops both.
  always_comb begin
    nib   = sh_dig_q[4*idx_q +: 4];
    seg_d = SEG_OFF;
    an_d  = '0;
    if (!dark[idx_q]) begin
      seg_d = {seg7_hex_decode(nib), sh_dp_q[idx_q]};
      if (en && (pwm_q <= bright)) an_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_lz_q    <= 1'b0;
      seg_q      <= SEG_IDLE;
      an_q       <= AN_IDLE;
      fs_q       <= 1'b0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      fs_q  <= 1'b0;
      if (div_last) begin
        div_q <= '0;
        if (idx_last) begin
          // Frame boundary: snapshot inputs so a frame never mixes old and new data.
          idx_q      <= '0;
          fs_q       <= 1'b1;
          sh_dig_q   <= digits;
          sh_dp_q    <= dp;
          sh_blank_q <= blank;
          sh_lz_q    <= lz_en;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      seg_q <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
      an_q  <= AN_ACTIVE_LOW ? ~an_d : an_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp, blank, bright;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int tests = 0;
  int fails = 0;

  seg7_scan_mux #(.DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .mclk(mclk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .lz_en(lz_en), .bright(bright), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 mclk = ~mclk;

  // Reference model: everything derives from k = clock edges since reset release.
  logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int          k;
  logic [15:0] sh_dig;
  logic [3:0]  sh_dp, sh_bl;
  logic        sh_lz;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_fs;

  function automatic logic m_dark(input int kk);
    int i = (kk / SD) % ND;
    return sh_bl[i] || (sh_lz && i != 0 && (sh_dig >> (4 * i)) == 16'h0);
  endfunction

  function automatic logic [7:0] m_seg(input int kk);
    int i = (kk / SD) % ND;
    logic [3:0] nb = 4'(sh_dig >> (4 * i));
    return m_dark(kk) ? 8'hFF : ~{GLY[nb], sh_dp[i]};
  endfunction

  function automatic logic [3:0] m_an(input int kk);
    int i = (kk / SD) % ND;
    logic [3:0] a = 4'hF;
    if (en && !m_dark(kk) && (kk % 16) <= int'(bright)) a[i] = 1'b0;
    return a;
  endfunction

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; sh_dig <= '0; sh_dp <= '0; sh_bl <= '0; sh_lz <= 1'b0;
      exp_seg <= 8'hFF; exp_an <= 4'hF; exp_fs <= 1'b0;
    end else begin
      exp_seg <= m_seg(k);
      exp_an  <= m_an(k);
      exp_fs  <= ((k + 1) % FR == 0);
      k       <= k + 1;
      if ((k + 1) % FR == 0) begin
        sh_dig <= digits; sh_dp <= dp; sh_bl <= blank; sh_lz <= lz_en;
      end
    end
  end

  always @(negedge mclk) begin
    tests++;
    if (seg !== exp_seg || an !== exp_an || frame_start !== exp_fs) begin
      fails++;
      $display("FAIL model k=%0d seg=%h exp %h an=%b exp %b fs=%b exp %b",
               k, seg, exp_seg, an, exp_an, frame_start, exp_fs);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic wait_fs(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge mclk);
      if (frame_start) seen = 1'b1;
    end
    if (!seen) chk("frame_start timeout", 0, 1);
  endtask

  // Release reset, pin the first displayed digit and the first frame_start cycle.
  task automatic rel_count();
    int n = 0;
    bit seen = 1'b0;
    @(negedge mclk);
    rst_n = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge mclk);
      n++;
      if (n == 1) begin
        chk("post-reset seg", seg, 8'h03);
        chk("post-reset an", an, 4'hE);
      end
      if (frame_start) seen = 1'b1;
    end
    chk("first frame_start cycle", n, 16);
  endtask

  task automatic frame_chk(input string nm, input logic [31:0] s, input logic [15:0] a);
    @(negedge mclk);
    for (int d = 0; d < ND; d++) begin
      chk({nm, " seg"}, seg, 8'(s >> (8 * d)));
      chk({nm, " an"}, an, 4'(a >> (4 * d)));
      repeat (SD) @(negedge mclk);
    end
  endtask

  task automatic count_on(input string nm, input int expv);
    int n = 0;
    repeat (32) begin
      @(negedge mclk);
      if (an != 4'hF) n++;
    end
    chk(nm, n, expv);
  endtask

  initial begin
    bit seen;
    logic [15:0] r;
    en = 1'b1; digits = '0; dp = '0; blank = '0; lz_en = 1'b0; bright = 4'd15;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("reset seg", seg, 8'hFF);
    chk("reset an", an, 4'hF);
    chk("reset fs", frame_start, 0);
    repeat (2) @(negedge mclk);
    rel_count();

    // Plain 1234 with dp on digit 1; slot order digit 0..3
    digits = 16'h1234; dp = 4'b0010;
    wait_fs(seen);
    frame_chk("1234", 32'h9F_25_0C_99, 16'h7BDE);

    // Leading-zero suppression
    digits = 16'h0050; dp = 4'b0000; lz_en = 1'b1;
    wait_fs(seen);
    frame_chk("lz 0050", 32'hFF_FF_49_03, 16'hFFDE);
    digits = 16'h0000;
    wait_fs(seen);
    frame_chk("lz 0000", 32'hFF_FF_FF_03, 16'hFFFE);

    // Mid-frame change must not tear
    lz_en = 1'b0; digits = 16'h1111;
    wait_fs(seen);
    @(negedge mclk);
    repeat (2 * SD) @(negedge mclk);
    digits = 16'h2222;
    repeat (SD) @(negedge mclk);
    chk("tear slot3 seg", seg, 8'h9F);
    chk("tear slot3 an", an, 4'h7);
    wait_fs(seen);
    @(negedge mclk);
    chk("next frame seg", seg, 8'h25);
    chk("next frame an", an, 4'hE);

    // PWM and enable
    bright = 4'd3;  count_on("pwm bright3 on-cycles", 8);
    bright = 4'd15; count_on("pwm bright15 on-cycles", 32);
    en = 1'b0;      count_on("en0 on-cycles", 0);
    wait_fs(seen);
    chk("en0 frame_start", seen, 1);
    en = 1'b1;

    // Reset mid-scan (idx 2)
    wait_fs(seen);
    @(negedge mclk);
    repeat (2 * SD) @(negedge mclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset seg", seg, 8'hFF);
    chk("midreset an", an, 4'hF);
    chk("midreset fs", frame_start, 0);
    rel_count();

    // Randomized run, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge mclk);
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 4; j++)
          r[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        digits = r;
        dp     = 4'($urandom);
        blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lz_en  = 1'($urandom);
        bright = 4'($urandom);
        en     = ($urandom_range(0, 5) != 0);
      end
      if (c == 700) begin
        #2 rst_n = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
